// File: rtl/parking_pkg.sv
// Shared parking definitions: seven-segment codes and binary-to-decimal helpers.
// Also used by the gate controller.
package parking_pkg;

    localparam int unsigned SegWidth = 7;

    typedef logic [SegWidth-1:0] seg_t;

    localparam seg_t SegBlank = 7'b1111111;

    // Active-low segment code for one decimal digit; non-digits show blank.
    function automatic seg_t seg_encode(input logic [3:0] digit);
        seg_t code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    // Compare/subtract chain: at most nine subtractions of ten cover 0..99.
    // Inputs above 99 are clamped so the result is always two valid digits.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = (bin > 7'd99) ? 7'd99 : bin;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // Tens digit with leading-zero suppression.
    function automatic seg_t seg_tens(input logic [6:0] bin);
        logic [7:0] bcd;
        bcd = bin_to_bcd(bin);
        return (bcd[7:4] == 4'd0) ? SegBlank : seg_encode(bcd[7:4]);
    endfunction

    // Units digit, always shown.
    function automatic seg_t seg_units(input logic [6:0] bin);
        logic [7:0] bcd;
        bcd = bin_to_bcd(bin);
        return seg_encode(bcd[3:0]);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one loop sensor.
// The output follows the synchronised input after DEBOUNCE_CYCLES consecutive
// cycles of disagreement; any agreeing cycle restarts the count.
module sensor_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic level_o
);

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync_q, sync_d;
    logic [7:0] cnt_q, cnt_d;
    logic       level_q, level_d;

    // Next state: shift the synchroniser, count disagreement, flip on the last one.
    always_comb begin
        sync_d  = {sync_q[0], raw_i};
        cnt_d   = 8'd0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // State registers; reset drops any pending change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= 8'd0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/park_occupancy.sv
// Car park occupancy: debounced entrance/exit sensors, free-slot counter with
// overflow/underflow rejection, and a two-digit seven-segment free-slot display.
module park_occupancy
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY        = 20,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       entrance_raw,
    input  logic       exit_raw,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [6:0] free_slots,
    output logic       full,
    output logic       empty,
    output logic       err_pulse,
    output logic [6:0] HEX_3,
    output logic [6:0] HEX_4
);

    localparam logic [6:0] Cap         = 7'(CAPACITY);
    localparam seg_t       HexTensRst  = seg_tens(Cap);
    localparam seg_t       HexUnitsRst = seg_units(Cap);

    logic       ent_db, ext_db;
    logic       entry_ev, exit_ev;
    logic       ent_prev_q, ent_prev_d;
    logic       ext_prev_q, ext_prev_d;
    logic [6:0] free_q, free_d;
    logic       err_q, err_d;
    seg_t       hex3_q, hex3_d;
    seg_t       hex4_q, hex4_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_entrance (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_i  (entrance_raw),
        .level_o(ent_db)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_exit (
        .clk    (clk),
        .reset_n(reset_n),
        .raw_i  (exit_raw),
        .level_o(ext_db)
    );

    // Events use the ungated entrance level so an entry while full is seen and rejected.
    assign entry_ev = ent_db & ~ent_prev_q;
    assign exit_ev  = ext_db & ~ext_prev_q;

    // Occupancy update: simultaneous events cancel with no error, even at the limits.
    always_comb begin
        ent_prev_d = ent_db;
        ext_prev_d = ext_db;
        free_d     = free_q;
        err_d      = 1'b0;
        if (entry_ev && !exit_ev) begin
            if (free_q == 7'd0) begin
                err_d = 1'b1;
            end else begin
                free_d = free_q - 7'd1;
            end
        end else if (exit_ev && !entry_ev) begin
            if (free_q == Cap) begin
                err_d = 1'b1;
            end else begin
                free_d = free_q + 7'd1;
            end
        end
    end

    // Display encode of the registered count; registered below, so it lags by one cycle.
    always_comb begin
        hex3_d = seg_tens(free_q);
        hex4_d = seg_units(free_q);
    end

    // State registers; the display loads the capacity digits asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_prev_q <= 1'b0;
            ext_prev_q <= 1'b0;
            free_q     <= Cap;
            err_q      <= 1'b0;
            hex3_q     <= HexTensRst;
            hex4_q     <= HexUnitsRst;
        end else begin
            ent_prev_q <= ent_prev_d;
            ext_prev_q <= ext_prev_d;
            free_q     <= free_d;
            err_q      <= err_d;
            hex3_q     <= hex3_d;
            hex4_q     <= hex4_d;
        end
    end

    assign free_slots      = free_q;
    assign full            = (free_q == 7'd0);
    assign empty           = (free_q == Cap);
    assign err_pulse       = err_q;
    assign sensor_entrance = ent_db & ~full;
    assign sensor_exit     = ext_db;
    assign HEX_3           = hex3_q;
    assign HEX_4           = hex4_q;

endmodule

// File: tb/tb_park_occupancy.sv
// Bench for park_occupancy: directed scenarios plus randomized sensor traffic,
// every cycle compared against a behavioural model of the car park.
module tb_park_occupancy;

    localparam int CAP = 20;
    localparam int DEB = 4;

    logic       clk;
    logic       reset_n;
    logic       entrance_raw;
    logic       exit_raw;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [6:0] free_slots;
    logic       full;
    logic       empty;
    logic       err_pulse;
    logic [6:0] HEX_3;
    logic [6:0] HEX_4;

    park_occupancy #(
        .CAPACITY       (CAP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .entrance_raw   (entrance_raw),
        .exit_raw       (exit_raw),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .free_slots     (free_slots),
        .full           (full),
        .empty          (empty),
        .err_pulse      (err_pulse),
        .HEX_3          (HEX_3),
        .HEX_4          (HEX_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;

    // Reference model state.
    bit hist_e[$];
    bit hist_x[$];
    bit m_db_e, m_db_x, m_prev_e, m_prev_x, m_err;
    int m_free;
    int m_hex_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] hex_tens_ref(input int v);
        return (v < 10) ? 7'b1111111 : seg_ref(v / 10);
    endfunction

    function automatic logic [6:0] hex_units_ref(input int v);
        return seg_ref(v % 10);
    endfunction

    task automatic model_reset();
        hist_e.delete();
        hist_x.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            hist_e.push_back(1'b0);
            hist_x.push_back(1'b0);
        end
        m_db_e    = 1'b0;
        m_db_x    = 1'b0;
        m_prev_e  = 1'b0;
        m_prev_x  = 1'b0;
        m_err     = 1'b0;
        m_free    = CAP;
        m_hex_val = CAP;
    endtask

    // One rising edge. A debounced level flips once the raw input, seen two
    // edges late, has opposed it for the last DEB sampled cycles in a row.
    task automatic model_edge(input bit e, input bit x);
        bit ev_e, ev_x, flip_e, flip_x;
        int n;
        ev_e   = m_db_e && !m_prev_e;
        ev_x   = m_db_x && !m_prev_x;
        flip_e = 1'b1;
        flip_x = 1'b1;
        n      = hist_e.size();
        for (int i = n - 1 - DEB; i <= n - 2; i++) begin
            if (hist_e[i] == m_db_e) flip_e = 1'b0;
            if (hist_x[i] == m_db_x) flip_x = 1'b0;
        end
        m_hex_val = m_free;
        m_err     = 1'b0;
        if (ev_e && !ev_x) begin
            if (m_free == 0) m_err = 1'b1;
            else m_free--;
        end else if (ev_x && !ev_e) begin
            if (m_free == CAP) m_err = 1'b1;
            else m_free++;
        end
        m_prev_e = m_db_e;
        m_prev_x = m_db_x;
        if (flip_e) m_db_e = !m_db_e;
        if (flip_x) m_db_x = !m_db_x;
        hist_e.push_back(e);
        hist_x.push_back(x);
        if (hist_e.size() > 64) begin
            void'(hist_e.pop_front());
            void'(hist_x.pop_front());
        end
    endtask

    task automatic check_all();
        check("free_slots", 32'(free_slots), 32'(m_free));
        check("full", 32'(full), 32'(m_free == 0));
        check("empty", 32'(empty), 32'(m_free == CAP));
        check("err_pulse", 32'(err_pulse), 32'(m_err));
        check("sensor_entrance", 32'(sensor_entrance), 32'(m_db_e && (m_free != 0)));
        check("sensor_exit", 32'(sensor_exit), 32'(m_db_x));
        check("HEX_3", 32'(HEX_3), 32'(hex_tens_ref(m_hex_val)));
        check("HEX_4", 32'(HEX_4), 32'(hex_units_ref(m_hex_val)));
    endtask

    // Called at a falling edge; drives inputs, models and checks one rising edge.
    task automatic cyc(input bit e, input bit x);
        entrance_raw = e;
        exit_raw     = x;
        @(posedge clk);
        model_edge(e, x);
        #1;
        check_all();
        if (err_pulse) err_seen++;
        @(negedge clk);
    endtask

    // Called at a falling edge; checks the asynchronous reset values before any edge.
    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic car_in();
        repeat (8) cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);
    endtask

    task automatic car_out();
        repeat (8) cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit e, x;
        int len;
        entrance_raw = 1'b0;
        exit_raw     = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset values with the default parameters.
        check("rst_free", 32'(free_slots), 32'd20);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_hex3", 32'(HEX_3), 32'(7'b0100100));
        check("rst_hex4", 32'(HEX_4), 32'(7'b1000000));

        // Short pulse is rejected; a held one qualifies six clocks later.
        repeat (3) cyc(1'b1, 1'b0);
        repeat (10) cyc(1'b0, 1'b0);
        check("short_pulse_free", 32'(free_slots), 32'd20);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b0);
            if (sensor_entrance) begin
                lat = i;
                break;
            end
        end
        check("entry_latency", 32'(lat), 32'd6);
        cyc(1'b1, 1'b0);
        check("entry_19", 32'(free_slots), 32'd19);
        repeat (8) cyc(1'b0, 1'b0);

        // Fill up, then one car too many.
        repeat (19) car_in();
        check("full_free", 32'(free_slots), 32'd0);
        check("full_flag", 32'(full), 32'd1);
        check("full_hex3", 32'(HEX_3), 32'(7'b1111111));
        check("full_hex4", 32'(HEX_4), 32'(7'b1000000));
        err_seen = 0;
        repeat (8) cyc(1'b1, 1'b0);
        check("full_gate", 32'(sensor_entrance), 32'd0);
        repeat (8) cyc(1'b0, 1'b0);
        check("overflow_err_cycles", 32'(err_seen), 32'd1);
        check("overflow_free", 32'(free_slots), 32'd0);

        // Simultaneous entry and exit at full.
        err_seen = 0;
        repeat (8) cyc(1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);
        check("simul_full_free", 32'(free_slots), 32'd0);
        check("simul_full_err", 32'(err_seen), 32'd0);
        car_out();
        check("one_out", 32'(free_slots), 32'd1);

        // Exit with the park empty, then simultaneous at empty.
        do_reset();
        err_seen = 0;
        car_out();
        check("underflow_err_cycles", 32'(err_seen), 32'd1);
        check("underflow_free", 32'(free_slots), 32'd20);
        err_seen = 0;
        repeat (8) cyc(1'b1, 1'b1);
        repeat (8) cyc(1'b0, 1'b0);
        check("simul_empty_free", 32'(free_slots), 32'd20);
        check("simul_empty_err", 32'(err_seen), 32'd0);

        // Glitching exit sensor.
        car_in();
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'(i % 2));
        repeat (8) cyc(1'b0, 1'b0);
        check("glitch_free", 32'(free_slots), 32'd19);

        // Reset in the middle of qualifying an entry, sensor held high throughout.
        do_reset();
        repeat (2) cyc(1'b1, 1'b0);
        entrance_raw = 1'b1;
        do_reset();
        check("midrst_free", 32'(free_slots), 32'd20);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b0);
            if (sensor_entrance) begin
                lat = i;
                break;
            end
        end
        check("midrst_latency", 32'(lat), 32'd6);
        cyc(1'b1, 1'b0);
        check("midrst_entry", 32'(free_slots), 32'd19);

        // Randomized traffic, biased slightly towards arrivals, with occasional resets.
        for (int s = 0; s < 300; s++) begin
            e   = ($urandom_range(0, 99) < 55);
            x   = ($urandom_range(0, 99) < 45);
            len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 59) == 0) begin
                entrance_raw = e;
                exit_raw     = x;
                do_reset();
            end
            repeat (len) cyc(e, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/park_occupancy.md
PARK_OCCUPANCY -- requirements
Module: park_occupancy

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 20: number of parking slots, legal range 1..99.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a debounced sensor changes, legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port entrance_raw, input, 1 bit: raw, unsynchronised entrance loop sensor.
REQ-006 The block SHALL have port exit_raw, input, 1 bit: raw, unsynchronised exit loop sensor.
REQ-007 The block SHALL have port sensor_entrance, output, 1 bit: debounced entrance level, gated low while full; feeds the gate controller.
REQ-008 The block SHALL have port sensor_exit, output, 1 bit: debounced exit level; feeds the gate controller.
REQ-009 The block SHALL have port free_slots, output, 7 bits: unsigned free-slot count.
REQ-010 The block SHALL have ports full and empty, outputs, 1 bit each: free_slots==0 and free_slots==CAPACITY respectively.
REQ-011 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse on a rejected event.
REQ-012 The block SHALL have ports HEX_3 and HEX_4, outputs, 7 bits each: active-low seven-segment tens and units digits of free_slots.

Function
REQ-013 Each raw sensor SHALL pass through a 2-flop synchroniser, then a debouncer whose output takes the synchronised value after DEBOUNCE_CYCLES consecutive cycles of disagreement; any agreeing cycle SHALL clear the debounce counter.
REQ-014 Latency from a stable raw change to the debounced level change SHALL be exactly 2+DEBOUNCE_CYCLES clocks.
REQ-015 An entry event SHALL be a 0->1 transition of the debounced entrance level; an exit event SHALL be a 0->1 transition of the debounced exit level; each event SHALL last one cycle.
REQ-016 The free_slots count SHALL update on the clock edge following the event cycle: entry decrements and exit increments.
REQ-017 An entry event while free_slots==0 SHALL leave the count unchanged and pulse err_pulse.
REQ-018 An exit event while free_slots==CAPACITY SHALL leave the count unchanged and pulse err_pulse.
REQ-019 Simultaneous entry and exit events SHALL leave the count unchanged with no err_pulse, including at full and at empty.
REQ-020 sensor_entrance SHALL equal debounced entrance AND NOT full; sensor_exit SHALL equal the debounced exit level.
REQ-021 full and empty SHALL be combinational decodes of the registered free_slots.
REQ-022 HEX_3 and HEX_4 SHALL be registered, lagging free_slots by one cycle.
REQ-023 Segment codes SHALL be active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
REQ-024 HEX_3 SHALL be blank when free_slots<10, so leading zeros are suppressed; HEX_4 SHALL always show the units digit.
REQ-025 Binary-to-decimal conversion SHALL use no divider; a compare/subtract chain bounded to 0..99 SHALL be used.

Reset
REQ-026 On reset_n low, all state SHALL clear asynchronously: free_slots=CAPACITY, synchronisers, debounced levels, debounce counters and previous-level flops=0, err_pulse=0.
REQ-027 On reset_n low, HEX_3 and HEX_4 SHALL take the CAPACITY digits immediately (asynchronous load), so the default resets to HEX_3=0100100 and HEX_4=1000000.
REQ-028 A reset asserted mid-debounce SHALL discard the pending change; the sensor SHALL requalify for the full 2+DEBOUNCE_CYCLES after release.
REQ-029 A sensor held high through reset release SHALL produce an event once debounced, because the debounced level resets to 0.

Structure
REQ-030 The seven-segment digit codes, the blank code and the width 7 SHALL live in a shared package/include parking_pkg, which is also used by the gate controller.
REQ-031 One sub-module, sensor_debounce (synchroniser plus counter, parameter DEBOUNCE_CYCLES), SHALL be instantiated twice.
REQ-032 Event detection, the occupancy counter and the display encoder SHALL reside in park_occupancy.

Verification
REQ-033 Reset check: reset with defaults -> free_slots=20, empty=1, full=0, HEX_3=0100100, HEX_4=1000000.
REQ-034 Debounce check: entrance_raw high 3 cycles then low (DEBOUNCE_CYCLES=4) -> no event and free_slots stays 20; entrance_raw held high -> sensor_entrance rises 6 clocks later and free_slots=19 one clock after that.
REQ-035 Full check: 20 clean entries -> free_slots=0, full=1, sensor_entrance forced 0, HEX_3=1111111, HEX_4=1000000; a 21st entry -> err_pulse for 1 cycle and the count stays 0.
REQ-036 Empty check: exit at free_slots=20 -> err_pulse and the count stays 20; entry+exit debounced in the same cycle at free_slots=0 -> count 0 and no err_pulse.
REQ-037 Glitch check: exit_raw toggling every cycle for 50 cycles -> no event and no count change.
REQ-038 Mid-debounce reset check: reset pulse 2 cycles after entrance_raw rises -> count 20 after release; the event occurs 6 clocks after release with the sensor still high.
